// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select of a shared
// 4:1 single-bit mux. It grants one requester at a time and registers the
// select, the grant and the muxed data bit.
// Optional build macro HOLD_TIMEOUT_EN: forces a release after MAX_HOLD
// consecutive grant cycles while another requester is waiting.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] w,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       f
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] s_nxt;
  logic       busy_nxt;

  logic       release_c;
  logic       timeout_c;
  logic [1:0] scan_base;
  logic [2:0] pick;

  // MAX_HOLD must fit the 4-bit hold counter and leave room for a handoff.
  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..15");
  end

  // First set bit of r, scanning base, base+1, base+2, base+3 (mod 4).
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the far end so the nearest hit to base overwrites the rest.
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef HOLD_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_cnt, hold_nxt;

  // The owner has used its full slot and someone else is queued.
  assign timeout_c = (hold_cnt == HOLD_LAST) && ((req & ~gnt) != 4'b0000);
`else
  assign timeout_c = 1'b0;
`endif

  // A release is either a voluntary drop of req[s] or a forced timeout.
  // On release, the scan restarts just past the owner so it ends up last.
  assign release_c = (state == GRANT) && (!req[s] || timeout_c);
  assign scan_base = release_c ? (s + 2'd1) : ptr;
  assign pick      = rr_pick(req, scan_base);

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    s_nxt     = s;
    busy_nxt  = busy;
`ifdef HOLD_TIMEOUT_EN
    hold_nxt  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << pick[1:0];
          s_nxt     = pick[1:0];
          busy_nxt  = 1'b1;
`ifdef HOLD_TIMEOUT_EN
          hold_nxt  = 4'd0;
`endif
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_nxt = scan_base;
          if (pick[2]) begin
            // Handoff at this edge, no idle bubble.
            gnt_nxt  = 4'b0001 << pick[1:0];
            s_nxt    = pick[1:0];
`ifdef HOLD_TIMEOUT_EN
            hold_nxt = 4'd0;
`endif
          end else begin
            // Nobody waiting: drop the grant but keep s at the last owner.
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
          end
        end else begin
`ifdef HOLD_TIMEOUT_EN
          if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 4'd1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Controller state, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      s     <= 2'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      s     <= s_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef HOLD_TIMEOUT_EN
  // Consecutive-grant counter, saturating at MAX_HOLD-1.
  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= 4'd0;
    else     hold_cnt <= hold_nxt;
  end
`endif

  // Shared data bit: muxed through the current select, one cycle behind gnt.
  always_ff @(posedge clk) begin
    if (rst) f <= 1'b0;
    else     f <= busy & w[s];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed stimulus, a behavioural reference
// model tracking the owner as an integer, and literal spot checks.
// Build with +define+HOLD_TIMEOUT_EN to exercise the timeout variant.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] w   = 4'b1111;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;
  logic       f;

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .w    (w),
    .gnt  (gnt),
    .s    (s),
    .busy (busy),
    .f    (f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when idle, else index of the granted
  // requester; held counts visible grant cycles without bound.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [1:0] m_s     = 2'd0;
  logic       m_f     = 1'b0;
  bit         chk_en  = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int  nxt;
    bit  rel;
    logic [3:0] others;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_s     = 2'd0;
      m_f     = 1'b0;
      chk_en  = 1'b1;
    end else begin
      m_f = (m_owner >= 0) ? w[m_s] : 1'b0;
      if (m_owner < 0) begin
        nxt = first_from(req, m_ptr);
        if (nxt >= 0) begin
          m_owner = nxt;
          m_s     = 2'(nxt);
          m_held  = 1;
        end
      end else begin
        rel    = !req[m_owner];
        others = req;
        others[m_owner] = 1'b0;
`ifdef HOLD_TIMEOUT_EN
        if (m_held >= MAX_HOLD && others != 4'b0000) rel = 1'b1;
`endif
        if (rel) begin
          m_ptr = (m_owner + 1) % 4;
          nxt   = first_from(req, m_ptr);
          if (nxt >= 0) begin
            m_owner = nxt;
            m_s     = 2'(nxt);
            m_held  = 1;
          end else begin
            m_owner = -1;
          end
        end else begin
          m_held++;
        end
      end
    end
  end

  // Every cycle after the first reset edge, outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt",  gnt, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      chk("model_s",    {2'b00, s},  {2'b00, m_s});
      chk("model_busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
      chk("model_f",    {3'b000, f},    {3'b000, m_f});
    end
  end

  // Apply inputs, then let exactly one rising edge sample them.
  task automatic cyc(input logic r_rst, input logic [3:0] r,
                     input logic [3:0] ww);
    rst = r_rst;
    req = r;
    w   = ww;
    @(negedge clk);
  endtask

  int held_cycles;

  initial begin
    // 1. Reset with everything requesting.
    cyc(1'b1, 4'b1111, 4'b1111);
    cyc(1'b1, 4'b1111, 4'b1111);
    chk("rst_gnt",  gnt, 4'b0000);
    chk("rst_s",    {2'b00, s}, 4'b0000);
    chk("rst_busy", {3'b000, busy}, 4'b0000);
    chk("rst_f",    {3'b000, f}, 4'b0000);
    cyc(1'b0, 4'b1111, 4'b1111);
    chk("first_gnt", gnt, 4'b0001);
    chk("first_s",   {2'b00, s}, 4'b0000);

    // 2. Single requester.
    cyc(1'b0, 4'b0000, 4'b0111);
    cyc(1'b0, 4'b0000, 4'b0111);
    cyc(1'b0, 4'b0100, 4'b0111);
    chk("single_gnt",  gnt, 4'b0100);
    chk("single_s",    {2'b00, s}, 4'b0010);
    chk("single_busy", {3'b000, busy}, 4'b0001);
    cyc(1'b0, 4'b0100, 4'b0111);
    chk("single_f", {3'b000, f}, 4'b0001);
    cyc(1'b0, 4'b0000, 4'b0111);
    chk("drop_gnt",  gnt, 4'b0000);
    chk("drop_busy", {3'b000, busy}, 4'b0000);
    chk("drop_s_hold", {2'b00, s}, 4'b0010);
    cyc(1'b0, 4'b0000, 4'b0111);
    chk("drop_f", {3'b000, f}, 4'b0000);

    // 3. Round-robin handoff from ptr=0.
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b1111, 4'b0000);
    chk("rr0_gnt", gnt, 4'b0001);
    cyc(1'b0, 4'b1111, 4'b0000);
    cyc(1'b0, 4'b1110, 4'b0000);
    chk("rr1_gnt", gnt, 4'b0010);
    chk("rr1_s",   {2'b00, s}, 4'b0001);
    cyc(1'b0, 4'b1111, 4'b0000);
    cyc(1'b0, 4'b1101, 4'b0000);
    chk("rr2_gnt", gnt, 4'b0100);
    chk("rr2_s",   {2'b00, s}, 4'b0010);
    cyc(1'b0, 4'b1111, 4'b0000);
    cyc(1'b0, 4'b1011, 4'b0000);
    chk("rr3_gnt", gnt, 4'b1000);
    chk("rr3_s",   {2'b00, s}, 4'b0011);
    cyc(1'b0, 4'b1111, 4'b0000);
    cyc(1'b0, 4'b0111, 4'b0000);
    chk("rr4_gnt", gnt, 4'b0001);
    chk("rr4_s",   {2'b00, s}, 4'b0000);

    // 4. Pointer wrap: requester 3 releases, then 0 and 3 ask together.
    cyc(1'b0, 4'b1000, 4'b1001);
    chk("wrap_own3", gnt, 4'b1000);
    cyc(1'b0, 4'b0000, 4'b1001);
    cyc(1'b0, 4'b1001, 4'b1001);
    chk("wrap_gnt", gnt, 4'b0001);
    cyc(1'b0, 4'b1001, 4'b1001);
    chk("wrap_f", {3'b000, f}, 4'b0001);

    // 5. Long hold by requester 0 with requester 2 waiting.
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0001, 4'b0000);
    held_cycles = (gnt == 4'b0001) ? 1 : 0;
    cyc(1'b0, 4'b0001, 4'b0000);
    if (gnt == 4'b0001) held_cycles++;
    cyc(1'b0, 4'b0001, 4'b0000);
    if (gnt == 4'b0001) held_cycles++;
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 4'b0101, 4'b0000);
      if (gnt == 4'b0001) held_cycles++;
      else break;
    end
    chk("timeout_len", 4'(held_cycles), 4'd8);
    chk("timeout_gnt", gnt, 4'b0100);
`else
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'b0101, 4'b0000);
      if (gnt == 4'b0001) held_cycles++;
    end
    chk("no_timeout_len", {3'b000, (held_cycles >= 20)}, 4'b0001);
    chk("no_timeout_gnt", gnt, 4'b0001);
`endif

    // 6. Reset in the middle of a grant.
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0010, 4'b0010);
    chk("mid_gnt", gnt, 4'b0010);
    cyc(1'b0, 4'b0010, 4'b0010);
    chk("mid_f", {3'b000, f}, 4'b0001);
    cyc(1'b1, 4'b0010, 4'b0010);
    chk("midrst_gnt",  gnt, 4'b0000);
    chk("midrst_s",    {2'b00, s}, 4'b0000);
    chk("midrst_busy", {3'b000, busy}, 4'b0000);
    chk("midrst_f",    {3'b000, f}, 4'b0000);
    cyc(1'b0, 4'b0010, 4'b0010);
    chk("postrst_gnt", gnt, 4'b0010);
    chk("postrst_s",   {2'b00, s}, 4'b0001);

    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
